// File: rtl/shared_bus_arbiter.sv
// -----------------------------------------------------------------------------
// shared_bus_arbiter
//
// Owns every driver on a shared tristate data bus. NUM_SRC sources request the
// bus with level-sensitive req bits; a round-robin arbiter grants exactly one
// of them at a time. An owner is forced off after MAX_HOLD cycles when someone
// else is waiting, and TURNAROUND all-Z cycles separate consecutive owners so
// two drivers can never overlap on the wires.
//
// Ports
//   clk        in     1                rising-edge clock for all state
//   rstIn      in     1                synchronous reset, active-high
//   req        in     NUM_SRC          per-source bus request (level)
//   src_data   in     NUM_SRC*WIDTH    source i data on [i*WIDTH +: WIDTH]
//   grant      out    NUM_SRC          registered one-hot (or zero) ownership
//   owner_id   out    clog2(NUM_SRC)   current owner; holds last value when idle
//   bus_valid  out    1                high while some source drives the bus
//   bus        inout  WIDTH            src_data[owner_id] when bus_valid, else Z
// -----------------------------------------------------------------------------
module shared_bus_arbiter #(
    parameter int WIDTH      = 16,
    parameter int NUM_SRC    = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       rstIn,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]         grant,
    output logic [$clog2(NUM_SRC)-1:0] owner_id,
    output logic                       bus_valid,
    inout  wire  [WIDTH-1:0]           bus
);

    localparam int IDW    = $clog2(NUM_SRC);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    localparam logic [IDW-1:0]    LAST_ID   = IDW'(NUM_SRC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t               state_r;
    logic [NUM_SRC-1:0]   grant_r;
    logic [IDW-1:0]       owner_id_r;
    logic                 bus_valid_r;
    logic [IDW-1:0]       rr_ptr_r;
    logic [HOLD_W-1:0]    hold_cnt_r;
    logic [TURN_W-1:0]    turn_cnt_r;

    logic [NUM_SRC-1:0]   others_s;
    logic                 release_s;
    logic [IDW-1:0]       next_ptr_s;
    logic [IDW-1:0]       win_s;
    logic [IDW-1:0]       win_others_s;
    logic [WIDTH-1:0]     sel_data_s;

    // First requester found scanning ptr, ptr+1, ... modulo NUM_SRC.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_SRC-1:0] mask,
                                               input logic [IDW-1:0]     ptr);
        logic found;
        int   idx;
        rr_pick = {IDW{1'b0}};
        found   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (!found && mask[idx]) begin
                rr_pick = IDW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // One-hot encoding of a source index.
    function automatic logic [NUM_SRC-1:0] onehot(input logic [IDW-1:0] idx);
        onehot      = {NUM_SRC{1'b0}};
        onehot[idx] = 1'b1;
    endfunction

    // Release decision, rotated pointer and the two arbitration candidates.
    always_comb begin
        others_s  = req & ~grant_r;
        release_s = 1'b0;
        if (!req[owner_id_r]) begin
            release_s = 1'b1;
        end else if ((hold_cnt_r == HOLD_LAST) && (|others_s)) begin
            release_s = 1'b1;
        end else begin
            release_s = 1'b0;
        end
        if (owner_id_r == LAST_ID) begin
            next_ptr_s = {IDW{1'b0}};
        end else begin
            next_ptr_s = owner_id_r + IDW'(1);
        end
        win_s        = rr_pick(req, rr_ptr_r);
        // Owner is already masked out of others_s, so scanning from the rotated
        // pointer gives the next requester after the outgoing owner.
        win_others_s = rr_pick(others_s, next_ptr_s);
        sel_data_s   = src_data[int'(owner_id_r) * WIDTH +: WIDTH];
    end

    // Arbitration FSM; grant/owner_id/bus_valid are registered here.
    always_ff @(posedge clk) begin
        if (rstIn) begin
            state_r     <= ST_IDLE;
            grant_r     <= {NUM_SRC{1'b0}};
            owner_id_r  <= {IDW{1'b0}};
            bus_valid_r <= 1'b0;
            rr_ptr_r    <= {IDW{1'b0}};
            hold_cnt_r  <= {HOLD_W{1'b0}};
            turn_cnt_r  <= {TURN_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        grant_r     <= onehot(win_s);
                        owner_id_r  <= win_s;
                        bus_valid_r <= 1'b1;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        state_r     <= ST_OWN;
                    end else begin
                        grant_r     <= {NUM_SRC{1'b0}};
                        bus_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (release_s) begin
                        rr_ptr_r <= next_ptr_s;
                        if (TURNAROUND == 0) begin
                            // Back-to-back hand-over: no idle cycle between owners.
                            if (|others_s) begin
                                grant_r     <= onehot(win_others_s);
                                owner_id_r  <= win_others_s;
                                bus_valid_r <= 1'b1;
                                hold_cnt_r  <= {HOLD_W{1'b0}};
                                state_r     <= ST_OWN;
                            end else begin
                                grant_r     <= {NUM_SRC{1'b0}};
                                bus_valid_r <= 1'b0;
                                state_r     <= ST_IDLE;
                            end
                        end else begin
                            grant_r     <= {NUM_SRC{1'b0}};
                            bus_valid_r <= 1'b0;
                            turn_cnt_r  <= {TURN_W{1'b0}};
                            state_r     <= ST_TURN;
                        end
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        // Limit reached but nobody waits: keep the bus, restart the window.
                        hold_cnt_r <= {HOLD_W{1'b0}};
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                ST_TURN: begin
                    if (turn_cnt_r == TURN_LAST) begin
                        if (|req) begin
                            grant_r     <= onehot(win_s);
                            owner_id_r  <= win_s;
                            bus_valid_r <= 1'b1;
                            hold_cnt_r  <= {HOLD_W{1'b0}};
                            state_r     <= ST_OWN;
                        end else begin
                            grant_r     <= {NUM_SRC{1'b0}};
                            bus_valid_r <= 1'b0;
                            state_r     <= ST_IDLE;
                        end
                    end else begin
                        turn_cnt_r <= turn_cnt_r + TURN_W'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant_r     <= {NUM_SRC{1'b0}};
                    bus_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign owner_id  = owner_id_r;
    assign bus_valid = bus_valid_r;

    // Data passes straight through from the selected source; only the select is registered.
    assign bus = bus_valid_r ? sel_data_s : {WIDTH{1'bz}};

endmodule

// File: tb/tb_shared_bus_arbiter.sv
module tb_shared_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_a;
    logic [3:0]  req_b;
    logic [63:0] src_data;
    logic [15:0] data [4];

    wire  [3:0]  grant_a;
    wire  [3:0]  grant_b;
    wire  [1:0]  owner_a;
    wire  [1:0]  owner_b;
    wire         valid_a;
    wire         valid_b;
    wire  [15:0] bus_a;
    wire  [15:0] bus_b;

    int total = 0;
    int bad   = 0;

    shared_bus_arbiter dut (
        .clk       (clk),
        .rstIn     (rst),
        .req       (req_a),
        .src_data  (src_data),
        .grant     (grant_a),
        .owner_id  (owner_a),
        .bus_valid (valid_a),
        .bus       (bus_a)
    );

    shared_bus_arbiter #(.TURNAROUND(0)) dut0 (
        .clk       (clk),
        .rstIn     (rst),
        .req       (req_b),
        .src_data  (src_data),
        .grant     (grant_b),
        .owner_id  (owner_b),
        .bus_valid (valid_b),
        .bus       (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_data();
        src_data = {data[3], data[2], data[1], data[0]};
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] o, input logic v);
        logic [15:0] eb;
        eb = v ? data[o] : 16'hzzzz;
        chk({tag, ".grant"},     {12'h000, grant_a}, {12'h000, g});
        chk({tag, ".owner_id"},  {14'h0000, owner_a}, {14'h0000, o});
        chk({tag, ".bus_valid"}, {15'h0000, valid_a}, {15'h0000, v});
        chk({tag, ".bus"},       bus_a, eb);
    endtask

    task automatic check_b(input string tag, input logic [3:0] g, input logic [1:0] o, input logic v);
        logic [15:0] eb;
        eb = v ? data[o] : 16'hzzzz;
        chk({tag, ".grant"},     {12'h000, grant_b}, {12'h000, g});
        chk({tag, ".owner_id"},  {14'h0000, owner_b}, {14'h0000, o});
        chk({tag, ".bus_valid"}, {15'h0000, valid_b}, {15'h0000, v});
        chk({tag, ".bus"},       bus_b, eb);
    endtask

    initial begin
        logic [1:0] o;
        data[0] = 16'h0A0A;
        data[1] = 16'h1B1B;
        data[2] = 16'hA5A5;
        data[3] = 16'h3C3C;
        pack_data();
        rst   = 1'b1;
        req_a = 4'b1111;
        req_b = 4'b0000;

        // reset held two cycles with every source requesting
        tick();
        tick();
        check_a("reset", 4'b0000, 2'd0, 1'b0);
        check_b("reset_t0", 4'b0000, 2'd0, 1'b0);

        // single requester, one-edge latency, data pass-through
        rst   = 1'b0;
        req_a = 4'b0100;
        tick();
        check_a("single_src2", 4'b0100, 2'd2, 1'b1);
        data[2] = 16'h1234;
        pack_data();
        #1;
        check_a("passthru_src2", 4'b0100, 2'd2, 1'b1);

        // reset mid-ownership drops grant; afterwards src0 wins first
        rst   = 1'b1;
        req_a = 4'b1111;
        tick();
        check_a("mid_reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();

        // all requesting: owners 0,1,2,3,0, 8 cycles each, one Z cycle between
        for (int n = 0; n < 5; n++) begin
            o = 2'(n % 4);
            for (int c = 0; c < 8; c++) begin
                check_a("rr_own", 4'b0001 << o, o, 1'b1);
                tick();
            end
            check_a("rr_gap", 4'b0000, o, 1'b0);
            if (n < 4) tick();
        end

        // lone requester keeps the bus across the hold limit
        req_a = 4'b0010;
        tick();
        for (int c = 0; c < 21; c++) begin
            check_a("solo_src1", 4'b0010, 2'd1, 1'b1);
            tick();
        end

        // owner 1 drops: gap, then src0 (pointer at 2 wraps to 0)
        req_a = 4'b0001;
        tick();
        check_a("drop_src1", 4'b0000, 2'd1, 1'b0);
        tick();
        check_a("own0_c1", 4'b0001, 2'd0, 1'b1);
        req_a = 4'b1001;
        tick();
        check_a("own0_c2", 4'b0001, 2'd0, 1'b1);
        tick();
        check_a("own0_c3", 4'b0001, 2'd0, 1'b1);
        // owner drops req in cycle 3: still drives until the edge
        req_a = 4'b1000;
        #1;
        check_a("own0_drop_cycle", 4'b0001, 2'd0, 1'b1);
        tick();
        check_a("own0_released", 4'b0000, 2'd0, 1'b0);
        tick();
        check_a("own3_after_gap", 4'b1000, 2'd3, 1'b1);

        // zero-turnaround instance: direct hand-over, then back, then idle
        req_b = 4'b0011;
        tick();
        for (int c = 0; c < 8; c++) begin
            check_b("t0_own0", 4'b0001, 2'd0, 1'b1);
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            check_b("t0_own1", 4'b0010, 2'd1, 1'b1);
            tick();
        end
        check_b("t0_back0", 4'b0001, 2'd0, 1'b1);
        req_b = 4'b0000;
        tick();
        check_b("t0_idle", 4'b0000, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
